// File: rtl/tile_cfg_pkg.sv
// Shared state encoding, config-address field layout and FIFO entry format
// for the tile configuration sequencer.
package tile_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_READ,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  // cfg_addr layout: [15:0] tile id, [23:16] feature, [31:24] register
  localparam int unsigned TILE_LSB = 0;
  localparam int unsigned TILE_W   = 16;
  localparam int unsigned FEAT_LSB = TILE_LSB + TILE_W;
  localparam int unsigned FEAT_W   = 8;
  localparam int unsigned REG_LSB  = FEAT_LSB + FEAT_W;
  localparam int unsigned REG_W    = 8;
  localparam int unsigned ADDR_W   = REG_LSB + REG_W;

  localparam int unsigned DEF_FIFO_DEPTH = 4;

  typedef struct packed {
    logic              last;
    logic [31:0]       data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  function automatic logic addr_hits(input logic [ADDR_W-1:0] addr,
                                     input logic [TILE_W-1:0] tid);
    return (addr[TILE_LSB +: TILE_W] == tid) && (addr != '0);
  endfunction

endpackage

// File: rtl/cfg_fifo.sv
// Synchronous FIFO with full/empty flags and a flush; the head entry is
// readable combinationally so the consumer can pop and capture in one cycle.
module cfg_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  always_ff @(posedge clk_in) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push && !o_full)  r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop  && !o_empty) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (i_push && !o_full) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/tile_config_sequencer.sv
// Buffers config entries, writes those addressed to this tile and optionally
// reads each one back; stops for good on the last entry or a read-back mismatch.
module tile_config_sequencer
  import tile_cfg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter bit          VERIFY     = 1'b1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [31:0]       cfg_data,
  input  logic              cfg_last,
  input  logic [TILE_W-1:0] tile_id,
  output logic [ADDR_W-1:0] tile_config_addr,
  output logic [31:0]       tile_config_data,
  output logic              tile_config_en,
  output logic              tile_read_en,
  input  logic [31:0]       tile_read_data,
  output logic              done,
  output logic              error,
  output logic [15:0]       write_count,
  output logic [ADDR_W-1:0] err_addr
);

  state_t            r_state, w_next;
  entry_t            w_in, w_head, r_hold;
  logic              w_full, w_empty, w_push, w_pop, w_cont;
  logic              w_issue, w_mismatch, w_flush;
  logic              r_hit, r_up;
  logic [ADDR_W-1:0] r_out_addr, r_err_addr;
  logic [31:0]       r_out_data;
  logic [15:0]       r_count;

  assign w_in    = '{last: cfg_last, data: cfg_data, addr: cfg_addr};
  assign w_push  = cfg_valid && cfg_ready;
  assign w_flush = (r_state == S_ERR);

  cfg_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .i_flush(w_flush),
    .i_push (w_push),
    .i_data (w_in),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign w_issue    = (r_state == S_ISSUE) && r_hit;
  assign w_mismatch = (tile_read_data != r_hold.data);

  // Strobes decode straight from state so read data lands in CHECK; reset
  // masks them in the cycle it is asserted.
  assign tile_config_en   = w_issue && !reset;
  assign tile_read_en     = (r_state == S_READ) && !reset;
  assign tile_config_addr = r_out_addr;
  assign tile_config_data = r_out_data;
  assign cfg_ready        = r_up && !w_full && (r_state != S_DONE) && (r_state != S_ERR);
  assign done             = (r_state == S_DONE);
  assign error            = (r_state == S_ERR);
  assign write_count      = r_count;
  assign err_addr         = r_err_addr;

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_cont = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_issue && VERIFY) w_next = S_READ;
        else                   w_cont = 1'b1;
      end
      S_READ:  w_next = S_CHECK;
      S_CHECK: begin
        if (w_mismatch) w_next = S_ERR;
        else            w_cont = 1'b1;
      end
      default: w_next = r_state;
    endcase
    if (w_cont) begin
      if (r_hold.last) begin
        w_next = S_DONE;
      end else if (!w_empty) begin
        w_pop  = 1'b1;
        w_next = S_ISSUE;
      end else begin
        w_next = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_up       <= 1'b0;
      r_hold     <= '0;
      r_hit      <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
      r_count    <= '0;
      r_err_addr <= '0;
    end else begin
      r_state <= w_next;
      r_up    <= 1'b1;
      if (w_pop) begin
        r_hold <= w_head;
        r_hit  <= addr_hits(w_head.addr, tile_id);
        // Tile-facing address/data only change for entries that will be written.
        if (addr_hits(w_head.addr, tile_id)) begin
          r_out_addr <= w_head.addr;
          r_out_data <= w_head.data;
        end
      end
      if (w_issue && (r_count != '1)) r_count <= r_count + 16'd1;
      if ((r_state == S_CHECK) && w_mismatch) r_err_addr <= r_hold.addr;
    end
  end

endmodule

// File: tb/tb_tile_config_sequencer.sv
// Directed and randomised streams for tile_config_sequencer (VERIFY=0 and
// VERIFY=1 instances), checked against a stream-level reference model.
module tb_tile_config_sequencer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        v[2], rdy[2], lst[2], ten[2], ren[2], dn[2], er[2];
  logic [31:0] a[2], d[2], taddr[2], tdata[2], rdat[2], eaddr[2];
  logic [15:0] tid[2], wcnt[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tile_config_sequencer #(
      .FIFO_DEPTH(DEPTH),
      .VERIFY    (g == 1)
    ) u_dut (
      .clk_in          (clk),
      .reset           (reset),
      .cfg_valid       (v[g]),
      .cfg_ready       (rdy[g]),
      .cfg_addr        (a[g]),
      .cfg_data        (d[g]),
      .cfg_last        (lst[g]),
      .tile_id         (tid[g]),
      .tile_config_addr(taddr[g]),
      .tile_config_data(tdata[g]),
      .tile_config_en  (ten[g]),
      .tile_read_en    (ren[g]),
      .tile_read_data  (rdat[g]),
      .done            (dn[g]),
      .error           (er[g]),
      .write_count     (wcnt[g]),
      .err_addr        (eaddr[g])
    );
  end

  // Monitor and tile model for the instance under test (cur).
  int unsigned cur = 0, sid = 0, sid_seen = 0, cyc = 0;
  int unsigned n_acc, n_wr, both_hi;
  int unsigned acc_c[$], wq_c[$];
  logic [31:0] wq_a[$], wq_d[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] bad_a = '0, bad_v = '0;

  always @(posedge clk) begin
    cyc++;
    if (sid != sid_seen) begin
      sid_seen = sid;
      n_acc = 0; n_wr = 0; both_hi = 0;
      acc_c.delete(); wq_c.delete(); wq_a.delete(); wq_d.delete(); mem.delete();
    end
    if (v[cur] && rdy[cur]) begin n_acc++; acc_c.push_back(cyc); end
    if (ten[cur] && ren[cur]) both_hi++;
    if (ten[cur]) begin
      n_wr++;
      wq_a.push_back(taddr[cur]); wq_d.push_back(tdata[cur]); wq_c.push_back(cyc);
      mem[taddr[cur]] = tdata[cur];
    end
    if (ren[cur])
      rdat[cur] <= (taddr[cur] == bad_a) ? bad_v :
                   (mem.exists(taddr[cur]) ? mem[taddr[cur]] : 32'h0);
  end

  int unsigned n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream under test and its expected outcome.
  logic [31:0] sa[$], sd[$], e_wa[$], e_wd[$];
  bit          sl[$];
  bit          e_done, e_err;
  logic [31:0] e_erra;
  logic [15:0] e_cnt;

  task automatic add(input logic [31:0] ad, input logic [31:0] da, input bit l);
    sa.push_back(ad); sd.push_back(da); sl.push_back(l);
  endtask

  task automatic clear_stream();
    sa.delete(); sd.delete(); sl.delete(); bad_a = '0; bad_v = '0;
  endtask

  // Walk entries in order: own non-zero addresses are written; with verify the
  // tile returns the written value unless it is the corrupted address.
  task automatic model(input bit ver, input logic [15:0] t);
    logic [31:0] ad, rb;
    e_wa.delete(); e_wd.delete();
    e_done = 0; e_err = 0; e_erra = '0; e_cnt = '0;
    for (int i = 0; i < sa.size(); i++) begin
      ad = sa[i];
      if (ad != 0 && ad[15:0] == t) begin
        e_wa.push_back(ad); e_wd.push_back(sd[i]);
        if (e_cnt != 16'hFFFF) e_cnt++;
        rb = (ad == bad_a) ? bad_v : sd[i];
        if (ver && rb != sd[i]) begin e_err = 1; e_erra = ad; return; end
      end
      if (sl[i]) begin e_done = 1; return; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; v[0] = 0; v[1] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_stream(input int unsigned g, input logic [15:0] t, input bit gaps,
                            input bit rst, input string nm);
    bit ok, stop;
    int unsigned k, nw;
    cur = g; tid[g] = t;
    if (rst) do_reset();
    sid++;
    model(g == 1, t);
    stop = 0;
    for (int i = 0; i < sa.size() && !stop; i++) begin
      v[g] = 1; a[g] = sa[i]; d[g] = sd[i]; lst[g] = sl[i];
      ok = 0; k = 0;
      while (!ok && !stop) begin
        if (dn[g] || er[g]) stop = 1;
        else if (k >= 64) begin stop = 1; chk({nm, ".accept_timeout"}, 0, 1); end
        else begin ok = rdy[g]; k++; @(negedge clk); end
      end
      v[g] = 0;
      if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
    end
    for (int w = 0; w < 300 && !(dn[g] || er[g]); w++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({nm, ".done"}, dn[g], e_done);
    chk({nm, ".error"}, er[g], e_err);
    chk({nm, ".err_addr"}, eaddr[g], e_erra);
    chk({nm, ".write_count"}, wcnt[g], e_cnt);
    chk({nm, ".n_strobes"}, wq_a.size(), e_wa.size());
    nw = (wq_a.size() < e_wa.size()) ? wq_a.size() : e_wa.size();
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("%s.wr%0d_addr", nm, i), wq_a[i], e_wa[i]);
      chk($sformatf("%s.wr%0d_data", nm, i), wq_d[i], e_wd[i]);
    end
    chk({nm, ".ready_terminal"}, rdy[g], 0);
    chk({nm, ".strobe_overlap"}, both_hi, 0);
  endtask

  task automatic gen(input int unsigned g, input logic [15:0] t);
    int unsigned n, r, idx;
    logic [31:0] ad;
    clear_stream();
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      ad = {8'($urandom), 8'($urandom), t};
      if (r == 0) ad = '0;
      else if (r < 3) ad[15:0] = t ^ 16'($urandom_range(1, 65535));
      add(ad, $urandom, i == n - 1);
    end
    if (g == 1 && $urandom_range(0, 2) == 0) begin
      idx = $urandom_range(0, n - 1);
      bad_a = sa[idx];
      bad_v = sd[idx] ^ (32'h1 << $urandom_range(0, 31));
    end
  endtask

  task automatic chk_outputs_zero(input int unsigned g, input string nm);
    chk({nm, ".cfg_ready"}, rdy[g], 0);
    chk({nm, ".config_en"}, ten[g], 0);
    chk({nm, ".read_en"}, ren[g], 0);
    chk({nm, ".config_addr"}, taddr[g], 0);
    chk({nm, ".config_data"}, tdata[g], 0);
    chk({nm, ".done"}, dn[g], 0);
    chk({nm, ".error"}, er[g], 0);
    chk({nm, ".write_count"}, wcnt[g], 0);
    chk({nm, ".err_addr"}, eaddr[g], 0);
  endtask

  initial begin : main
    int occ;
    bit saw_full, seen;
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      v[g] = 0; a[g] = '0; d[g] = '0; lst[g] = 0; tid[g] = 16'h18;
    end
    repeat (3) @(negedge clk);
    chk_outputs_zero(0, "reset0");
    chk_outputs_zero(1, "reset1");
    reset = 1'b0;
    #1;
    chk("reset.ready_same_cycle0", rdy[0], 0);
    chk("reset.ready_same_cycle1", rdy[1], 0);
    @(negedge clk);
    chk("reset.ready_rises0", rdy[0], 1);
    chk("reset.ready_rises1", rdy[1], 1);

    // Two own entries, no verify: back-to-back strobes, two-cycle latency.
    clear_stream();
    add(32'h00FF0018, 32'h1, 0);
    add(32'h00000018, 32'h5, 1);
    run_stream(0, 16'h18, 0, 1, "s1");
    chk("s1.latency", (wq_c.size() > 0 && acc_c.size() > 0) ? wq_c[0] - acc_c[0] : 0, 2);
    chk("s1.spacing", (wq_c.size() > 1) ? wq_c[1] - wq_c[0] : 0, 1);

    // Foreign entry is skipped, own last entry completes.
    clear_stream();
    add(32'h00000017, 32'hA, 0);
    add(32'h01000018, 32'hB, 1);
    run_stream(0, 16'h18, 0, 1, "s2");

    // Verify: first read-back matches, second returns 6 for data 7.
    clear_stream();
    add(32'h00000018, 32'h5, 0);
    add(32'h02000018, 32'h7, 1);
    bad_a = 32'h02000018; bad_v = 32'h6;
    run_stream(1, 16'h18, 0, 1, "s3");
    chk("s3.spacing", (wq_c.size() > 1) ? wq_c[1] - wq_c[0] : 0, 3);

    // Zero address with last: nothing written, still completes.
    clear_stream();
    add(32'h0, 32'h0, 1);
    run_stream(0, 16'h18, 0, 1, "s6a");
    clear_stream();
    add(32'h0, 32'h0, 1);
    run_stream(1, 16'h18, 0, 1, "s6b");

    // Fill: valid held high against the 3-cycle verify loop.
    clear_stream();
    cur = 1; tid[1] = 16'h18;
    do_reset();
    sid++;
    v[1] = 1; a[1] = 32'h03000018; d[1] = 32'h99; lst[1] = 0;
    saw_full = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      occ = int'(n_acc) - int'(n_wr) - (ten[1] ? 1 : 0);
      chk("fill.occ_le_depth", 32'(occ <= int'(DEPTH)), 1);
      if (!rdy[1]) begin
        saw_full = 1;
        chk("fill.occ_at_stall", 32'(occ), DEPTH);
      end
    end
    chk("fill.ready_fell", saw_full, 1);
    v[1] = 0;

    // Reset pulse while a read-back strobe is active.
    clear_stream();
    do_reset();
    sid++;
    v[1] = 1; a[1] = 32'h04000018; d[1] = 32'h1; lst[1] = 0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = ren[1];
    end
    chk("rst.read_seen", seen, 1);
    reset = 1'b1; v[1] = 0;
    sid++;
    #1;
    chk("rst.read_en_aborted", ren[1], 0);
    chk("rst.config_en_aborted", ten[1], 0);
    @(negedge clk);
    chk_outputs_zero(1, "rst");
    reset = 1'b0;
    #1;
    chk("rst.ready_low_at_release", rdy[1], 0);
    @(negedge clk);
    chk("rst.ready_rises", rdy[1], 1);
    chk("rst.no_write", n_wr, 0);
    add(32'h05000018, 32'h11, 0);
    add(32'h06000018, 32'h22, 0);
    add(32'h07000018, 32'h33, 1);
    run_stream(1, 16'h18, 0, 0, "rst.restart");

    for (int rep = 0; rep < 24; rep++) begin
      int unsigned g;
      logic [15:0] t;
      g = rep % 2;
      t = 16'($urandom);
      gen(g, t);
      run_stream(g, t, 1, 1, $sformatf("rnd%0d", rep));
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/tile_config_sequencer.md
TILE_CONFIG_SEQUENCER -- requirements
Module: tile_config_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: depth of the entry buffer (power of two, at least 2).
REQ-002 Parameter VERIFY, default 1: 1 = read back and compare every write; 0 = write only.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Ports (name  direction  width  meaning) SHALL be:
- clk_in  in  1  clock
- reset  in  1  synchronous active-high reset
- cfg_valid  in  1  config entry offered
- cfg_ready  out  1  entry accepted when valid&ready
- cfg_addr  in  32  [15:0] tile id, [23:16] feature, [31:24] register
- cfg_data  in  32  config payload
- cfg_last  in  1  final entry of bitstream
- tile_id  in  16  id of the controlled tile (static)
- tile_config_addr  out  32  address to tile
- tile_config_data  out  32  data to tile
- tile_config_en  out  1  one-cycle write strobe
- tile_read_en  out  1  one-cycle read-back strobe
- tile_read_data  in  32  tile read-back, valid the cycle after tile_read_en
- done  out  1  sticky, bitstream complete
- error  out  1  sticky, read-back mismatch
- write_count  out  16  writes issued to this tile
- err_addr  out  32  address of first mismatch

Function
REQ-005 Accepted entries (addr, data, last) SHALL enter a FIFO_DEPTH FIFO; cfg_ready = !full && state not DONE/ERR; no bypass.
REQ-006 FSM states SHALL be IDLE, ISSUE, READ, CHECK, DONE, ERR.
REQ-007 IDLE: on FIFO non-empty, pop the head into a holding register and go to ISSUE.
REQ-008 ISSUE: if held addr[15:0]==tile_id and addr!=0, drive tile_config_addr/data, pulse tile_config_en, and increment write_count (saturating at 16'hFFFF); otherwise issue nothing.
REQ-009 Leaving ISSUE after a write with VERIFY=1: go to READ. Otherwise: go to DONE if held last=1; else pop the next entry back-to-back into ISSUE if non-empty, or go to IDLE.
REQ-010 READ: pulse tile_read_en with the same address; go to CHECK.
REQ-011 CHECK: compare tile_read_data to held data.
- Mismatch: capture err_addr, set error, go to ERR.
- Match: go to DONE if last=1; else continue as in REQ-009.
REQ-012 Entries with addr==0 or a foreign tile id SHALL be consumed without a write; a non-matching entry with last=1 still completes.
REQ-013 Latency: an entry accepted at edge N SHALL reach tile_config_en at the earliest in cycle N+2.
REQ-014 Throughput SHALL be one entry per cycle (VERIFY=0) or one write per 3 cycles (VERIFY=1).
REQ-015 DONE and ERR SHALL be terminal until reset; done=1 in DONE, error=1 in ERR; FIFO contents left in ERR are discarded.
REQ-016 Simultaneous push and pop SHALL keep occupancy unchanged; a push while full is impossible (ready low).
REQ-017 tile_config_en and tile_read_en SHALL never be high in the same cycle.

Reset
REQ-018 Reset SHALL drive state to IDLE and empty the FIFO.
REQ-019 Reset SHALL clear to 0: cfg_ready, tile_config_en, tile_read_en, tile_config_addr, tile_config_data, done, error, write_count, err_addr.
REQ-020 cfg_ready SHALL rise the cycle after reset deasserts.
REQ-021 Reset asserted mid-operation SHALL abort any strobe in that cycle; no partial write is issued afterwards.

Structure
REQ-022 Package tile_cfg_pkg SHALL hold the state enum, field LSB/width constants (tile id, feature, register), and the default FIFO_DEPTH.
REQ-023 The FIFO SHALL be a separate sub-module cfg_fifo (parameterised width and depth, with full and empty flags).

Verification
REQ-024 Bench scenarios:
- tile_id=16'h18, VERIFY=0; entries (00FF0018, 1), (00000018, 5, last) -> two strobes, write_count=2, done=1.
- Foreign entry 00000017 then own 01000018 with last -> one strobe only, write_count=1.
- VERIFY=1; tile echoes 5 for data 5, then returns 6 for data 7 at 02000018 -> error=1, err_addr=02000018, cfg_ready=0.
- Hold tile_config_en unobserved with cfg_valid held high -> cfg_ready falls after FIFO_DEPTH accepts; occupancy never exceeds FIFO_DEPTH.
- Reset pulse during READ -> all outputs 0 next cycle; a new stream runs to done normally.
- addr 0 / data 0 entry with last=1 -> no strobe, done=1.
